dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Sequencer and arbiter for the single-port data memory behind the MEM stage. It takes the CPU access carried by the EX/MEM pipeline register (MemRead/MemWrite, ALU result as address, store data) and a debug/loader requester. It drives a req/ack memory handshake and stalls the pipeline until the CPU access completes. CPU has fixed priority over debug, optionally relaxed by a starvation guard.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 8, pending-debug cycles before debug is forced ahead of CPU (guard builds only)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cpu_rd_i  in  1  MemRead from EX/MEM
- cpu_wr_i  in  1  MemWrite from EX/MEM
- cpu_addr_i  in  ADDR_W  ALU result from EX/MEM
- cpu_wdata_i  in  DATA_W  store data from EX/MEM
- cpu_rdata_o  out  DATA_W  load data, registered
- cpu_stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- dbg_req_i  in  1  debug request, level, held until dbg_done_o
- dbg_we_i  in  1  debug write enable
- dbg_addr_i  in  ADDR_W  debug address
- dbg_wdata_i  in  DATA_W  debug write data
- dbg_gnt_o  out  1  one-cycle pulse at debug grant
- dbg_done_o  out  1  one-cycle pulse at debug completion
- dbg_rdata_o  out  DATA_W  debug read data, registered
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with ack
- mem_ack_i  in  1  memory completion, one cycle

## Operation
- cpu_req = cpu_rd_i | cpu_wr_i. Both high: treat as write.
- States: IDLE, CPU_BUSY, CPU_DONE, DBG_BUSY.
- In IDLE, arbitration order:
  - forced debug (guard builds only);
  - cpu_req → CPU_BUSY;
  - dbg_req_i → DBG_BUSY, with a dbg_gnt_o pulse.
- On grant, register mem_we_o, mem_addr_o and mem_wdata_o from the winner. Hold them stable until ack.
- mem_req_o = 1 exactly while in CPU_BUSY or DBG_BUSY.
- CPU_BUSY + mem_ack_i → CPU_DONE. Capture cpu_rdata_o on a read. On a write, cpu_rdata_o holds its value.
- CPU_DONE → IDLE unconditionally. No issue is made in CPU_DONE. This guarantees the held EX/MEM request is not replayed.
- DBG_BUSY + mem_ack_i → IDLE, with a dbg_done_o pulse. Capture dbg_rdata_o on a read.
- cpu_stall_o is combinational and equals cpu_req & (state != CPU_DONE).
- mem_ack_i is ignored in IDLE and CPU_DONE.
- Reset values: state IDLE; every output 0, including the rdata registers; starvation counter 0.
- Reset mid-transaction abandons the access. A late ack after reset is ignored.

## Timing
- CPU access against a 1-cycle-ack memory:
  - c0: IDLE, stall=1, grant.
  - c1: CPU_BUSY, req=1, ack, stall=1.
  - c2: CPU_DONE, stall=0, rdata valid.
- Each extra memory wait cycle adds one stall cycle.
- Debug arriving while the CPU is busy waits until at least the IDLE cycle after CPU_DONE. A CPU request in that same IDLE cycle wins unless debug is forced.
- Back-to-back CPU accesses: minimum 3 cycles each.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - A counter increments each cycle dbg_req_i=1 and no debug grant occurs. It saturates at STARVE_MAX.
  - At STARVE_MAX, the next IDLE arbitration grants debug even if cpu_req=1.
  - The counter clears on debug grant and whenever dbg_req_i=0.
- Undefined: strict CPU priority. The counter and STARVE_MAX logic are absent. Debug can starve indefinitely.

## Structure
- Shared package riscv_pipe_pkg holds:
  - typedef dmem_arb_state_t (4 states, 2-bit encoding);
  - default ADDR_W/DATA_W constants.
- Sub-module dmem_starve_ctr (saturating pending counter with force output). It is instantiated only under DMEM_ARB_STARVE_GUARD_EN.

## Test plan
- CPU load from addr 0x40, memory acks after 1 cycle with 0xDEADBEEF → stall high for exactly 2 cycles; cpu_rdata_o=0xDEADBEEF in CPU_DONE; mem_req_o high for 1 cycle.
- CPU store of 0x12345678 to 0x80, ack delayed 3 cycles → mem_addr_o/mem_wdata_o stable for all 3 cycles; stall high for 4 cycles; single mem_req_o burst.
- dbg_req_i and cpu_req rise in the same cycle, guard off → CPU served first; dbg_gnt_o pulses in the IDLE after CPU_DONE; dbg_done_o pulses one cycle after ack.
- Guard on, STARVE_MAX=8, cpu_req held continuously, debug pending → debug is granted at the first IDLE after the counter reaches 8; counter reads 0 after grant.
- rst_i asserted in CPU_BUSY, stray mem_ack_i two cycles after release → all outputs 0; state stays IDLE; no rdata capture.
- cpu_rd_i=cpu_wr_i=1 at addr 0x10 → mem_we_o=1 (write wins).

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pipe_pkg
//  Description : Shared pipeline types and default widths for the MEM stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

  localparam int c_defAddrW = 32;
  localparam int c_defDataW = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    CPU_DONE = 2'd2,
    DBG_BUSY = 2'd3
  } dmem_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_starve_ctr
//  Description : Saturating pending-debug counter; force_o at STARVE_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_starve_ctr #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pend_i,
  input  logic grant_i,
  output logic force_o
);

  localparam int c_cntW = $clog2(STARVE_MAX + 1);
  localparam logic [c_cntW-1:0] c_max = c_cntW'(STARVE_MAX);

  logic [c_cntW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (!pend_i || grant_i) begin
      r_cnt <= '0;
    end else if (r_cnt != c_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign force_o = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Data-memory sequencer/arbiter, CPU (EX/MEM) over debug port.
//                Optional starvation guard: DMEM_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
  import riscv_pipe_pkg::*;
#(
  parameter int ADDR_W = c_defAddrW,
  parameter int DATA_W = c_defDataW
`ifdef DMEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 8
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  dmem_arb_state_t r_state;

  logic w_cpuReq;
  logic w_forceDbg;
  logic w_dbgGrant;
  logic w_cpuGrant;

  assign w_cpuReq = cpu_rd_i | cpu_wr_i;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starveCtr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pend_i  (dbg_req_i),
    .grant_i (w_dbgGrant),
    .force_o (w_forceDbg)
  );
`else
  assign w_forceDbg = 1'b0;
`endif

  // The requester still holds dbg_req_i while dbg_done_o is up; no regrant then.
  assign w_dbgGrant = (r_state == IDLE) && dbg_req_i && !dbg_done_o
                      && (w_forceDbg || !w_cpuReq);
  assign w_cpuGrant = (r_state == IDLE) && w_cpuReq && !w_dbgGrant;

  assign dbg_gnt_o   = w_dbgGrant;
  assign cpu_stall_o = w_cpuReq && (r_state != CPU_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      cpu_rdata_o <= '0;
      dbg_done_o  <= 1'b0;
      dbg_rdata_o <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      dbg_done_o <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_dbgGrant) begin
            r_state     <= DBG_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dbg_we_i;
            mem_addr_o  <= dbg_addr_i;
            mem_wdata_o <= dbg_wdata_i;
          end else if (w_cpuGrant) begin
            r_state     <= CPU_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= cpu_wr_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
          end
        end
        CPU_BUSY: begin
          if (mem_ack_i) begin
            r_state   <= CPU_DONE;
            mem_req_o <= 1'b0;
            if (!mem_we_o) cpu_rdata_o <= mem_rdata_i;
          end
        end
        // One dead cycle lets the pipeline advance before EX/MEM is sampled again.
        CPU_DONE: r_state <= IDLE;
        DBG_BUSY: begin
          if (mem_ack_i) begin
            r_state    <= IDLE;
            mem_req_o  <= 1'b0;
            dbg_done_o <= 1'b1;
            if (!mem_we_o) dbg_rdata_o <= mem_rdata_i;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Scoreboard bench for dmem_port_arbiter with a latency-driven
//                memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_rd_i, cpu_wr_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_stall_o;
  logic        dbg_req_i, dbg_we_i;
  logic [31:0] dbg_addr_i, dbg_wdata_i, dbg_rdata_o;
  logic        dbg_gnt_o, dbg_done_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  logic        respAck = 1'b0;
  logic        strayAck = 1'b0;
  logic [31:0] respData = '0;
  logic [31:0] strayData = 32'hBAD0_BAD0;

  assign mem_ack_i   = respAck | strayAck;
  assign mem_rdata_i = strayAck ? strayData : respData;

  always #5 clk_i = ~clk_i;

  dmem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef DMEM_ARB_STARVE_GUARD_EN
    , .STARVE_MAX (8)
`endif
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_rd_i    (cpu_rd_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .dbg_req_i   (dbg_req_i),
    .dbg_we_i    (dbg_we_i),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_wdata_i (dbg_wdata_i),
    .dbg_gnt_o   (dbg_gnt_o),
    .dbg_done_o  (dbg_done_o),
    .dbg_rdata_o (dbg_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } memTxn_t;

  memTxn_t expQ[$];
  int      vecCnt = 0;
  int      missCnt = 0;
  int      latency = 1;
  int      reqCycles = 0;
  int      reqCnt = 0;
  memTxn_t curTxn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memModel(input logic [31:0] addr);
    return (addr == 32'h40) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
  endfunction

  task automatic tick;
    @(negedge clk_i);
    #1;
  endtask

  // Memory responder: pops the scoreboard at each new request, checks the
  // request is held steady, and acks after 'latency' request cycles.
  always @(negedge clk_i) begin
    respAck = 1'b0;
    if (mem_req_o && !rst_i) begin
      if (reqCnt == 0) begin
        if (expQ.size() == 0) begin
          chk("spuriousReq", 32'(mem_req_o), 32'd0);
          curTxn = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o};
        end else begin
          curTxn = expQ.pop_front();
          chk("reqWe", 32'(mem_we_o), 32'(curTxn.we));
          chk("reqAddr", mem_addr_o, curTxn.addr);
          chk("reqWdata", mem_wdata_o, curTxn.wdata);
        end
      end else begin
        chk("holdAddr", mem_addr_o, curTxn.addr);
        chk("holdWdata", mem_wdata_o, curTxn.wdata);
      end
      reqCnt++;
      reqCycles++;
      if (reqCnt >= latency) begin
        respAck  = 1'b1;
        respData = memModel(mem_addr_o);
        reqCnt   = 0;
      end
    end else begin
      reqCnt = 0;
    end
  end

  task automatic checkAllZero(input string pfx);
    chk({pfx, "_cpuRdata"}, cpu_rdata_o, 32'd0);
    chk({pfx, "_stall"}, 32'(cpu_stall_o), 32'd0);
    chk({pfx, "_gnt"}, 32'(dbg_gnt_o), 32'd0);
    chk({pfx, "_done"}, 32'(dbg_done_o), 32'd0);
    chk({pfx, "_dbgRdata"}, dbg_rdata_o, 32'd0);
    chk({pfx, "_memReq"}, 32'(mem_req_o), 32'd0);
    chk({pfx, "_memWe"}, 32'(mem_we_o), 32'd0);
    chk({pfx, "_memAddr"}, mem_addr_o, 32'd0);
    chk({pfx, "_memWdata"}, mem_wdata_o, 32'd0);
  endtask

  task automatic cpuAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat,
                           output int stallCyc, output int reqCyc,
                           output logic [31:0] rdataAtDone);
    latency   = lat;
    reqCycles = 0;
    expQ.push_back('{we: wr, addr: addr, wdata: wdata});
    cpu_rd_i    = rd;
    cpu_wr_i    = wr;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    #1;
    stallCyc = 0;
    for (int k = 0; k < 30; k++) begin
      if (!cpu_stall_o) break;
      stallCyc++;
      tick();
    end
    rdataAtDone = cpu_rdata_o;
    reqCyc      = reqCycles;
    cpu_rd_i    = 1'b0;
    cpu_wr_i    = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    int          sc, rc, gntAt, doneAt, cpuDoneAt;
    logic [31:0] rd;

    rst_i = 1'b1;
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    tick(); tick();
    checkAllZero("inReset");
    rst_i = 1'b0;
    tick();
    checkAllZero("afterReset");

    // CPU load, 1-cycle ack
    cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 1, sc, rc, rd);
    chk("ldStallCycles", 32'(sc), 32'd2);
    chk("ldReqCycles", 32'(rc), 32'd1);
    chk("ldRdata", rd, 32'hDEAD_BEEF);

    // CPU store, 3-cycle ack; load data must hold
    cpuAccess(1'b0, 1'b1, 32'h80, 32'h1234_5678, 3, sc, rc, rd);
    chk("stStallCycles", 32'(sc), 32'd4);
    chk("stReqCycles", 32'(rc), 32'd3);
    chk("stRdataHeld", rd, 32'hDEAD_BEEF);

    // Read and write together: write wins, no capture
    cpuAccess(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 1, sc, rc, rd);
    chk("rwStallCycles", 32'(sc), 32'd2);
    chk("rwRdataHeld", rd, 32'hDEAD_BEEF);

    // Debug and CPU arrive together: CPU first
    latency = 1;
    expQ.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    expQ.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h20; cpu_wdata_i = 32'h0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h100; dbg_wdata_i = 32'h0;
    #1;
    gntAt = -1; doneAt = -1; cpuDoneAt = -1; rd = '0;
    for (int k = 0; k < 20; k++) begin
      if (dbg_gnt_o && gntAt < 0) gntAt = k;
      if (cpu_rd_i && !cpu_stall_o && cpuDoneAt < 0) begin
        cpuDoneAt = k;
        chk("arbCpuRdata", cpu_rdata_o, memModel(32'h20));
        cpu_rd_i = 1'b0;
      end
      if (dbg_done_o) begin
        doneAt = k;
        rd = dbg_rdata_o;
        dbg_req_i = 1'b0;
        break;
      end
      tick();
    end
    chk("arbCpuDoneCycle", 32'(cpuDoneAt), 32'd2);
    chk("arbDbgGntCycle", 32'(gntAt), 32'd3);
    chk("arbDbgDoneCycle", 32'(doneAt), 32'd5);
    chk("arbDbgRdata", rd, memModel(32'h100));
    tick();
    chk("arbNoRegrant", 32'(dbg_gnt_o), 32'd0);
    chk("arbIdleNoReq", 32'(mem_req_o), 32'd0);

    // Reset in CPU_BUSY, then a stray ack
    latency = 20;
    expQ.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h44;
    tick(); tick();
    chk("rstPreBusy", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    cpu_rd_i = 1'b0; cpu_addr_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    latency = 1;
    tick(); tick();
    strayAck = 1'b1;
    tick();
    strayAck = 1'b0;
    checkAllZero("strayAck");
    tick();
    checkAllZero("strayAckLater");

`ifdef DMEM_ARB_STARVE_GUARD_EN
    // CPU hammers the port; debug must be forced in after 8 pending cycles
    for (int i = 0; i < 3; i++) expQ.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    expQ.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h77});
    cpu_rd_i = 1'b1; cpu_addr_i = 32'h200;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h300; dbg_wdata_i = 32'h77;
    #1;
    gntAt = -1; doneAt = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 8) chk("starveCntSat", 32'(dut.u_starveCtr.r_cnt), 32'd8);
      if (gntAt >= 0 && k == gntAt + 1)
        chk("starveCntClr", 32'(dut.u_starveCtr.r_cnt), 32'd0);
      if (dbg_gnt_o && gntAt < 0) gntAt = k;
      if (dbg_done_o) begin
        doneAt = k;
        cpu_rd_i = 1'b0;
        dbg_req_i = 1'b0;
        break;
      end
      tick();
    end
    chk("starveGntCycle", 32'(gntAt), 32'd9);
    chk("starveDoneCycle", 32'(doneAt), 32'd11);
    tick();
`endif

    tick();
    chk("queueDrained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
`default_nettype wire
